// File: rtl/dsp_dma_bus_responder.sv
// -----------------------------------------------------------------------------
// dsp_dma_bus_responder
//
// DSP-side responder for DMA memory cycles into DSP RAM. Arbitrates the RAM
// between DSP program accesses (DSPBUSY, always wins) and DMA requests, raises
// the bus acknowledge (DSPBAK/DSPBAKL), stretches each DMA cycle with WAIT,
// performs the single RAM read or write, and terminates the cycle by tracking
// MREQL/ST23L from the DMA cycle generator.
//
// Ports:
//   CLK, RESET        clock and synchronous active-high reset
//   DMAREQ            DMA bus request (level, held for a burst)
//   DMA0WRL           0 = DMA write into RAM, 1 = read
//   MREQL, ST23L      DMA memory strobe / cycle state 2-3 indicator (active low)
//   DMAADDR/DMAWDATA  DMA address and write data, valid while MREQL low
//   DSPBUSY           DSP program owns the RAM this cycle
//   DSPBAK/DSPBAKL    bus acknowledge and its inverse
//   WAIT              stretch the DMA cycle
//   RAMADDR/RAMWDATA  RAM address / write data
//   RAMWE/RAMRD       one-cycle RAM write / read strobes
//   RAMRDATA          RAM read data, valid the cycle after RAMRD
//   DMARDATA/RDVALID  read data to DMA (held) and its one-cycle update pulse
//   PROTERR           sticky protocol-error flag, cleared only by RESET
//
// Optional feature macro: DMA_HOLD_TIMEOUT_EN
//   When defined, a grant left idle (MREQL high) for HOLD_TIMEOUT consecutive
//   cycles raises PROTERR and releases the bus. When undefined the grant is
//   held for as long as DMAREQ stays high and the HOLD_TIMEOUT parameter and
//   its counter do not exist.
// -----------------------------------------------------------------------------
module dsp_dma_bus_responder #(
   parameter int ADDR_W       = 9,
   parameter int DATA_W       = 16,
`ifdef DMA_HOLD_TIMEOUT_EN
   parameter int HOLD_TIMEOUT = 15,
`endif
   parameter int WAIT_STATES  = 1
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              DMAREQ,
   input  logic              DMA0WRL,
   input  logic              MREQL,
   input  logic              ST23L,
   input  logic [ADDR_W-1:0] DMAADDR,
   input  logic [DATA_W-1:0] DMAWDATA,
   input  logic              DSPBUSY,
   output logic              DSPBAK,
   output logic              DSPBAKL,
   output logic              WAIT,
   output logic [ADDR_W-1:0] RAMADDR,
   output logic [DATA_W-1:0] RAMWDATA,
   output logic              RAMWE,
   output logic              RAMRD,
   input  logic [DATA_W-1:0] RAMRDATA,
   output logic [DATA_W-1:0] DMARDATA,
   output logic              RDVALID,
   output logic              PROTERR
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GRANT,
      S_WAITST,
      S_ACCESS,
      S_DONE,
      S_RELEASE
   } state_t;

   localparam logic [2:0] WS_LOAD = 3'(WAIT_STATES);

   state_t              state_q, state_d;
   logic                bak_q, bak_d;
   logic                bakl_q, bakl_d;
   logic                wait_q, wait_d;
   logic                ramwe_q, ramwe_d;
   logic                ramrd_q, ramrd_d;
   logic                rdvalid_q, rdvalid_d;
   logic                proterr_q, proterr_d;
   logic [ADDR_W-1:0]   ramaddr_q, ramaddr_d;
   logic [DATA_W-1:0]   ramwdata_q, ramwdata_d;
   logic [DATA_W-1:0]   dmardata_q, dmardata_d;
   logic                wr_q, wr_d;          // captured direction: 1 = write
   logic [2:0]          wcnt_q, wcnt_d;      // remaining WAIT cycles
   // Read return sequencing in DONE: 2 = RAMRD cycle (RAM samples address),
   // 1 = RAMRDATA valid and gets latched, 0 = nothing pending.
   logic [1:0]          rd_stage_q, rd_stage_d;

`ifdef DMA_HOLD_TIMEOUT_EN
   localparam logic [3:0] HOLD_LAST = 4'(HOLD_TIMEOUT - 1);
   logic [3:0]          hold_cnt_q, hold_cnt_d;
`endif

   always_comb begin
      state_d    = state_q;
      bak_d      = bak_q;
      wait_d     = wait_q;
      ramwe_d    = 1'b0;
      ramrd_d    = 1'b0;
      rdvalid_d  = 1'b0;
      proterr_d  = proterr_q;
      ramaddr_d  = ramaddr_q;
      ramwdata_d = ramwdata_q;
      dmardata_d = dmardata_q;
      wr_d       = wr_q;
      wcnt_d     = wcnt_q;
      rd_stage_d = rd_stage_q;
`ifdef DMA_HOLD_TIMEOUT_EN
      hold_cnt_d = 4'd0;
`endif

      case (state_q)
         S_IDLE: begin
            bak_d  = 1'b0;
            wait_d = 1'b0;
            if (!MREQL) begin
               // A memory strobe without a grant is a DMA-side fault.
               proterr_d = 1'b1;
               state_d   = S_RELEASE;
            end else if (DMAREQ && !DSPBUSY) begin
               bak_d   = 1'b1;
               state_d = S_GRANT;
            end
         end

         S_GRANT: begin
            // MREQL is checked before DMAREQ so an access that starts on the
            // same edge as DMAREQ falling still completes before release.
            if (!MREQL) begin
               ramaddr_d = DMAADDR;
               wr_d      = ~DMA0WRL;
               if (!DMA0WRL) begin
                  ramwdata_d = DMAWDATA;
               end
               if (WAIT_STATES == 0) begin
                  wait_d  = 1'b0;
                  state_d = S_ACCESS;
               end else begin
                  wait_d  = 1'b1;
                  wcnt_d  = WS_LOAD;
                  state_d = S_WAITST;
               end
            end else if (!DMAREQ) begin
               state_d = S_RELEASE;
            end
`ifdef DMA_HOLD_TIMEOUT_EN
            else if (hold_cnt_q == HOLD_LAST) begin
               proterr_d = 1'b1;
               state_d   = S_RELEASE;
            end else begin
               hold_cnt_d = hold_cnt_q + 4'd1;
            end
`endif
         end

         S_WAITST: begin
            if (ST23L) begin
               proterr_d = 1'b1;
               wait_d    = 1'b0;
               state_d   = S_RELEASE;
            end else if (!DSPBUSY) begin
               // Counter freezes while the DSP holds the RAM.
               if (wcnt_q <= 3'd1) begin
                  wait_d  = 1'b0;
                  state_d = S_ACCESS;
               end else begin
                  wcnt_d = wcnt_q - 3'd1;
               end
            end
         end

         S_ACCESS: begin
            if (ST23L) begin
               proterr_d = 1'b1;
               wait_d    = 1'b0;
               state_d   = S_RELEASE;
            end else if (DSPBUSY) begin
               wait_d = 1'b1;
            end else begin
               wait_d     = 1'b0;
               ramwe_d    = wr_q;
               ramrd_d    = ~wr_q;
               rd_stage_d = wr_q ? 2'd0 : 2'd2;
               state_d    = S_DONE;
            end
         end

         S_DONE: begin
            if (rd_stage_q == 2'd2) begin
               rd_stage_d = 2'd1;
            end else begin
               if (rd_stage_q == 2'd1) begin
                  dmardata_d = RAMRDATA;
                  rdvalid_d  = 1'b1;
                  rd_stage_d = 2'd0;
               end
               if (ST23L) begin
                  state_d = DMAREQ ? S_GRANT : S_RELEASE;
               end
            end
         end

         S_RELEASE: begin
            bak_d   = 1'b0;
            wait_d  = 1'b0;
            state_d = S_IDLE;
         end

         default: begin
            bak_d   = 1'b0;
            wait_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase

      bakl_d = ~bak_d;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= S_IDLE;
         bak_q      <= 1'b0;
         bakl_q     <= 1'b1;
         wait_q     <= 1'b0;
         ramwe_q    <= 1'b0;
         ramrd_q    <= 1'b0;
         rdvalid_q  <= 1'b0;
         proterr_q  <= 1'b0;
         ramaddr_q  <= '0;
         ramwdata_q <= '0;
         dmardata_q <= '0;
         wr_q       <= 1'b0;
         wcnt_q     <= 3'd0;
         rd_stage_q <= 2'd0;
`ifdef DMA_HOLD_TIMEOUT_EN
         hold_cnt_q <= 4'd0;
`endif
      end else begin
         state_q    <= state_d;
         bak_q      <= bak_d;
         bakl_q     <= bakl_d;
         wait_q     <= wait_d;
         ramwe_q    <= ramwe_d;
         ramrd_q    <= ramrd_d;
         rdvalid_q  <= rdvalid_d;
         proterr_q  <= proterr_d;
         ramaddr_q  <= ramaddr_d;
         ramwdata_q <= ramwdata_d;
         dmardata_q <= dmardata_d;
         wr_q       <= wr_d;
         wcnt_q     <= wcnt_d;
         rd_stage_q <= rd_stage_d;
`ifdef DMA_HOLD_TIMEOUT_EN
         hold_cnt_q <= hold_cnt_d;
`endif
      end
   end

   assign DSPBAK   = bak_q;
   assign DSPBAKL  = bakl_q;
   assign WAIT     = wait_q;
   assign RAMADDR  = ramaddr_q;
   assign RAMWDATA = ramwdata_q;
   assign RAMWE    = ramwe_q;
   assign RAMRD    = ramrd_q;
   assign DMARDATA = dmardata_q;
   assign RDVALID  = rdvalid_q;
   assign PROTERR  = proterr_q;

endmodule
